// File: rtl/logic_unit_pipe_pkg.sv
// Shared definitions for the pipelined logic unit: function-select encoding
// and the output-register state type.
package logic_unit_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_AND  = 3'd0;
  localparam op_t OP_OR   = 3'd1;
  localparam op_t OP_XOR  = 3'd2;
  localparam op_t OP_NAND = 3'd3;
  localparam op_t OP_NOR  = 3'd4;
  localparam op_t OP_XNOR = 3'd5;
  localparam op_t OP_NOT  = 3'd6;
  localparam op_t OP_PASS = 3'd7;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } ostate_t;

endpackage

// File: rtl/logic_unit_pipe_if.sv
// Handshake/data bundle for logic_unit_pipe. The master drives operands and
// out_ready; the slave (the unit) returns readiness, result and flags.
interface logic_unit_pipe_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  import logic_unit_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  op_t              op;
  logic             acc_mode;
  logic             acc_load;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             out_zero;
  logic             out_parity;
  logic [CNT_W-1:0] txn_count;

  modport master (
    output in_valid, a, b, op, acc_mode, acc_load, out_ready,
    input  in_ready, out_valid, result, out_zero, out_parity, txn_count
  );

  modport slave (
    input  in_valid, a, b, op, acc_mode, acc_load, out_ready,
    output in_ready, out_valid, result, out_zero, out_parity, txn_count
  );

endinterface

// File: rtl/logic_unit_pipe_core.sv
// Purely combinational bitwise function block: f = op(x, y), full width,
// no carries between bits.
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  input  op_t              i_op,
  output logic [WIDTH-1:0] o_f
);

  // Function select
  always_comb begin
    o_f = '0;
    case (i_op)
      OP_AND:  o_f = i_x & i_y;
      OP_OR:   o_f = i_x | i_y;
      OP_XOR:  o_f = i_x ^ i_y;
      OP_NAND: o_f = ~(i_x & i_y);
      OP_NOR:  o_f = ~(i_x | i_y);
      OP_XNOR: o_f = ~(i_x ^ i_y);
      OP_NOT:  o_f = ~i_x;
      OP_PASS: o_f = i_x;
      default: o_f = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit with valid/ready handshake and accumulate mode.
// Optional registered result parity when LOGIC_UNIT_PARITY_EN is defined.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input logic             clk,
  input logic             rst_n,
  logic_unit_pipe_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  ostate_t          r_state;
  ostate_t          w_state_nxt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             w_parity;
  logic [CNT_W-1:0] r_count;

  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_load;
  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_y;
  logic [WIDTH-1:0] w_f;
  logic [WIDTH-1:0] w_res;

  assign w_in_fire  = bus.in_valid && w_in_ready;
  assign w_out_fire = w_out_valid && bus.out_ready;
  assign w_load     = bus.acc_mode && bus.acc_load;

  // Operand selection: accumulate mode folds a into the accumulator
  always_comb begin
    w_x = bus.a;
    w_y = bus.b;
    if (bus.acc_mode) begin
      w_x = r_acc;
      w_y = bus.a;
    end else begin
      w_x = bus.a;
      w_y = bus.b;
    end
  end

  logic_unit_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .i_x  (w_x),
    .i_y  (w_y),
    .i_op (bus.op),
    .o_f  (w_f)
  );

  // Value written to the result (and accumulator) on an input fire
  always_comb begin
    w_res = w_f;
    if (w_load) begin
      w_res = bus.a;
    end else begin
      w_res = w_f;
    end
  end

  // Output register state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Output register next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_fire) begin
          w_state_nxt = ST_FULL;
        end else begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_out_fire && !w_in_fire) begin
          w_state_nxt = ST_EMPTY;
        end else begin
          w_state_nxt = ST_FULL;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // Handshake outputs; in_ready passes out_ready through with no skid buffer
  always_comb begin
    w_out_valid = 1'b0;
    w_in_ready  = 1'b1;
    case (r_state)
      ST_EMPTY: begin
        w_out_valid = 1'b0;
        w_in_ready  = 1'b1;
      end
      ST_FULL: begin
        w_out_valid = 1'b1;
        w_in_ready  = bus.out_ready;
      end
      default: begin
        w_out_valid = 1'b0;
        w_in_ready  = 1'b1;
      end
    endcase
  end

  // Result, zero flag, accumulator and beat counter; all move only on input fire
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_result <= '0;
      r_zero   <= 1'b0;
      r_acc    <= '0;
      r_count  <= '0;
    end else if (w_in_fire) begin
      r_result <= w_res;
      r_zero   <= (w_res == '0);
      r_count  <= r_count + CNT_ONE;
      if (bus.acc_mode) begin
        r_acc <= w_res;
      end
    end
  end

`ifdef LOGIC_UNIT_PARITY_EN
  logic r_parity;

  function automatic logic f_parity(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  // Parity of the held result, registered alongside it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_parity <= 1'b0;
    end else if (w_in_fire) begin
      r_parity <= f_parity(w_res);
    end
  end

  assign w_parity = r_parity;
`else
  assign w_parity = 1'b0;
`endif

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.result     = r_result;
  assign bus.out_zero   = r_zero;
  assign bus.out_parity = w_parity;
  assign bus.txn_count  = r_count;

endmodule

// File: doc/logic_unit_pipe.md
# logic_unit_pipe

Parametrised, registered bitwise logic unit for the gate-level library. Executes one of eight two-operand bitwise functions on `WIDTH`-bit operands under a valid/ready handshake, with a one-stage output register. An optional accumulate mode folds a stream of operands into an internal register. It supersedes one-bit combinational gate blocks wherever results must be pipelined or back-pressured.

## Interface
- `WIDTH`, 8, operand/result width in bits (≥1)
- `CNT_W`, 16, transaction counter width (≥1)

- `clk`  in  1  rising-edge clock, sole clock
- `rst_n`  in  1  synchronous, active-low reset
- `in_valid`  in  1  input beat present
- `in_ready`  out  1  unit can accept a beat this cycle
- `a`  in  WIDTH  operand A
- `b`  in  WIDTH  operand B (ignored in accumulate mode)
- `op`  in  3  function select
- `acc_mode`  in  1  1 = accumulate mode for this beat
- `acc_load`  in  1  with `acc_mode`, seed accumulator from `a`
- `out_valid`  out  1  result register holds a beat
- `out_ready`  in  1  downstream accepts result
- `result`  out  WIDTH  registered result
- `out_zero`  out  1  `result == 0`
- `out_parity`  out  1  XOR-reduction of `result` (see Configuration)
- `txn_count`  out  CNT_W  number of accepted input beats, wraps

## Operation
- Input fire: `in_valid && in_ready`. Output fire: `out_valid && out_ready`.
- Operand pair (x, y): normal mode x=`a`, y=`b`; accumulate mode x=`acc`, y=`a`.
- `op` encoding: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT (~x), 7 PASS (x). All bitwise, full `WIDTH`, no carries.
- Accumulate beat, `acc_load`=0: f = op(acc, a); `acc` ← f; `result` ← f.
- Accumulate beat, `acc_load`=1: `acc` ← `a`; `result` ← `a`; `op` ignored.
- `acc_load` without `acc_mode`: ignored.
- Normal-mode beats never modify `acc`.
- `acc`, `result`, flags, and `txn_count` update only on input fire. Inputs are sampled only on input fire.
- Output register states:
  - EMPTY (`out_valid`=0).
  - FULL (`out_valid`=1).
- State transitions:
  - EMPTY + input fire → FULL.
  - FULL + output fire, no input fire → EMPTY.
  - FULL + output fire + input fire → FULL, holding the new beat.
  - FULL without output fire → FULL, with `result` and flags held stable.
- `in_ready` = `!out_valid || out_ready`. This is combinational from `out_ready`; there is no skid buffer.
- `txn_count` increments by 1 per input fire and wraps from 2^CNT_W−1 to 0.
- `out_zero` and `out_parity` are registered alongside `result` and describe the held `result`.

## Timing
- Latency: 1 cycle. A beat fired at edge N is visible on `result`/`out_valid` after edge N.
- Throughput: 1 beat/cycle while `out_ready`=1.
- Accumulate chain: back-to-back accumulate beats see the `acc` written by the previous fire. No bubbles are needed.
- Reset (`rst_n`=0 at a rising edge) clears the following to 0, overriding any fire in the same cycle:
  - `out_valid`, `result`, `out_zero` (reset value 0), `out_parity`, `acc`, `txn_count`.
- `in_ready` reads 1 during and after reset.
- Reset mid-stream discards the held result and the accumulator; no partial state survives.
- `out_ready` may toggle freely while EMPTY with no effect.

## Configuration
- `LOGIC_UNIT_PARITY_EN` defined: `out_parity` = registered ^`result`, updated with `result`.
- Not defined: `out_parity` is constant 0 and no parity logic is synthesised.
- The port list is identical in both builds.

## Structure
- Shared package `logic_unit_pkg`:
  - `op` encoding constants: `OP_AND`, `OP_OR`, `OP_XOR`, `OP_NAND`, `OP_NOR`, `OP_XNOR`, `OP_NOT`, `OP_PASS`.
  - Op-type typedef, 3 bits.
- One sub-module `logic_unit_core`: purely combinational, (x, y, op) → f, parametrised by `WIDTH`.
- Top level contains:
  - operand muxing
  - accumulator
  - output register / handshake
  - flags
  - counter

## Test plan
- **All ops:** WIDTH=8, `out_ready`=1, a=8'hC5, b=8'h3A, op 0..7 → result 00, FF, FF, FF, 00, 00, 3A, C5. `out_zero` is 1 for ops 0, 4, 5.
- **Back-pressure:** `out_ready`=0 for 3 cycles after first beat, `in_valid` held high →
  - `in_ready`=0, with `result` and flags stable.
  - Release → next beat accepted the same cycle and appears 1 cycle later.
  - `txn_count`=2.
- **Accumulate XOR:** load a=8'h0F, then XOR beats a=8'hF0, 8'hFF, 8'h01 back-to-back → results 0F, FF, 00, 01. `out_zero` is 1 on the third beat.
- **Mode isolation:** accumulate-load 8'hAA, normal AND beat a=8'hFF/b=8'h0F (result 0F), then accumulate OR a=8'h01 → result AB.
- **Reset mid-operation:** `rst_n`=0 while FULL and `in_valid`=1 → next cycle:
  - `out_valid`=0, `result`=0, `acc`=0, `txn_count`=0.
  - A subsequent accumulate AND with a=8'hFF yields 00.
- **Counter wrap and parity:** CNT_W=2, 5 beats → `txn_count` sequence 1, 2, 3, 0, 1. With `LOGIC_UNIT_PARITY_EN`, result 8'h07 gives `out_parity`=1; without the macro it is always 0.
